// File: rtl/xlib_stream_w2p_mlane.sv
// -----------------------------------------------------------------------------
// xlib_stream_w2p_mlane
// Multi-lane word-to-primitive unpacker. Input words of DW bits are appended to
// a byte buffer. Up to LANES primitives of P = bpp+1 bytes each are emitted per
// output beat. Frame ends drain the buffer and produce a partial last beat with
// a lane-valid mask and a fragment flag.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   clr_n         synchronous clear (active low), drops buffered bytes
//   bpp           bytes per primitive minus one
//   m_rdy/m_val/m_eof/m_dat           input word stream
//   s_rdy/s_val/s_eof/s_keep/s_frag/s_dat  output primitive beats
// -----------------------------------------------------------------------------
module xlib_stream_w2p_mlane #(
    parameter  int unsigned BW    = 8,
    parameter  int unsigned DW    = 32,
    parameter  int unsigned PW    = 32,
    parameter  int unsigned LANES = 2,
    localparam int unsigned WB    = DW / BW,
    localparam int unsigned PB    = PW / BW,
    localparam int unsigned CAP   = WB + LANES * PB,
    localparam int unsigned BPPW  = (PB > 1) ? $clog2(PB) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_n,
    input  logic [BPPW-1:0]       bpp,
    output logic                  m_rdy,
    input  logic                  m_val,
    input  logic                  m_eof,
    input  logic [DW-1:0]         m_dat,
    input  logic                  s_rdy,
    output logic                  s_val,
    output logic                  s_eof,
    output logic [LANES-1:0]      s_keep,
    output logic                  s_frag,
    output logic [LANES*PW-1:0]   s_dat
);

    localparam int unsigned CW  = $clog2(CAP + 1);
    localparam int unsigned CIW = $clog2(CAP);
    localparam int unsigned WIW = (WB > 1) ? $clog2(WB) : 1;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [BW-1:0]   r_buf     [CAP];
    logic [BW-1:0]   w_buf_nxt [CAP];
    logic [BW-1:0]   w_mbyte   [WB];
    logic [LANES-1:0] w_full;
    logic            w_acc;
    logic            w_emit;
    int unsigned     w_p;
    int unsigned     w_k;
    int unsigned     w_tail;
    int unsigned     w_rem;
    int unsigned     w_base;

    // Primitive size, number of whole primitives held (capped at LANES), leftover bytes
    always_comb begin
        w_p    = 32'(bpp) + 1;
        w_k    = 0;
        w_full = '0;
        for (int unsigned j = 1; j <= LANES; j++) begin
            w_full[j-1] = (32'(r_cnt) >= j * w_p);
            if (32'(r_cnt) >= j * w_p) begin
                w_k = j;
            end
        end
        w_tail = 32'(r_cnt) - w_k * w_p;
    end

    // Split the input word into bytes, byte 0 in the low bits
    always_comb begin
        for (int unsigned b = 0; b < WB; b++) begin
            w_mbyte[b] = m_dat[b*BW +: BW];
        end
    end

    assign w_acc  = m_val && m_rdy;
    assign w_emit = s_val && s_rdy;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: eof word enters DRAIN, the eof beat returns to ACCUM
    always_comb begin
        w_state_nxt = r_state;
        if (!clr_n) begin
            w_state_nxt = ST_ACCUM;
        end else begin
            case (r_state)
                ST_ACCUM: if (w_acc && m_eof)  w_state_nxt = ST_DRAIN;
                ST_DRAIN: if (w_emit && s_eof) w_state_nxt = ST_ACCUM;
                default:                       w_state_nxt = ST_ACCUM;
            endcase
        end
    end

    // Outputs are decoded from the registered buffer and state only
    always_comb begin
        m_rdy  = (r_state == ST_ACCUM) && (32'(r_cnt) + WB <= CAP);
        s_val  = (r_state == ST_DRAIN) || w_full[LANES-1];
        s_eof  = (r_state == ST_DRAIN) && (w_tail < w_p);
        s_frag = s_eof && (w_tail != 0);
        s_keep = s_val ? w_full : '0;
        s_dat  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            for (int unsigned b = 0; b < PB; b++) begin
                if (s_keep[i] && (b < w_p)) begin
                    s_dat[(i*PB+b)*BW +: BW] = r_buf[CIW'(i * w_p + b)];
                end
            end
        end
    end

    // Shift out emitted bytes and append the accepted word in one step
    always_comb begin
        w_rem = 0;
        if (w_emit) begin
            w_rem = s_eof ? 32'(r_cnt) : w_k * w_p;
        end
        w_base = 32'(r_cnt) - w_rem;
        for (int unsigned j = 0; j < CAP; j++) begin
            w_buf_nxt[j] = '0;
            if (j + w_rem < CAP) begin
                w_buf_nxt[j] = r_buf[CIW'(j + w_rem)];
            end
            if (w_acc && (j >= w_base) && (j < w_base + WB)) begin
                w_buf_nxt[j] = w_mbyte[WIW'(j - w_base)];
            end
        end
        w_cnt_nxt = CW'(32'(r_cnt) + (w_acc ? WB : 0) - w_rem);
    end

    // Byte buffer and fill count; clear drops the count, stale bytes are never read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            for (int unsigned j = 0; j < CAP; j++) begin
                r_buf[j] <= '0;
            end
        end else if (!clr_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_buf <= w_buf_nxt;
        end
    end

endmodule

// File: tb/tb_xlib_stream_w2p_mlane.sv
// -----------------------------------------------------------------------------
// tb_xlib_stream_w2p_mlane
// Directed scenarios plus a randomized run against a byte-queue reference model.
// -----------------------------------------------------------------------------
module tb_xlib_stream_w2p_mlane;

    localparam int unsigned BW    = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned PW    = 32;
    localparam int unsigned LANES = 2;
    localparam int unsigned WB    = 4;
    localparam int unsigned CAP   = 12;
    localparam int unsigned SDW   = LANES * PW;

    typedef struct packed {
        logic [LANES-1:0] keep;
        logic             eof;
        logic             frag;
        logic [SDW-1:0]   dat;
    } beat_t;

    typedef struct packed {
        logic          eof;
        logic [DW-1:0] dat;
    } word_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr_n;
    logic [1:0]       bpp;
    logic             m_rdy;
    logic             m_val;
    logic             m_eof;
    logic [DW-1:0]    m_dat;
    logic             s_rdy;
    logic             s_val;
    logic             s_eof;
    logic [LANES-1:0] s_keep;
    logic             s_frag;
    logic [SDW-1:0]   s_dat;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    stall_cnt = 0;
    bit    gap_en   = 1'b0;
    word_t in_q[$];
    beat_t cap_q[$];

    xlib_stream_w2p_mlane #(.BW(BW), .DW(DW), .PW(PW), .LANES(LANES)) dut (
        .clk    (clk),
        .rst    (rst),
        .clr_n  (clr_n),
        .bpp    (bpp),
        .m_rdy  (m_rdy),
        .m_val  (m_val),
        .m_eof  (m_eof),
        .m_dat  (m_dat),
        .s_rdy  (s_rdy),
        .s_val  (s_val),
        .s_eof  (s_eof),
        .s_keep (s_keep),
        .s_frag (s_frag),
        .s_dat  (s_dat)
    );

    always #5 clk = ~clk;

    // Word feeder: presents the head of in_q, pops it once accepted
    initial begin
        bit acc;
        m_val = 1'b0;
        m_eof = 1'b0;
        m_dat = '0;
        forever begin
            @(negedge clk);
            acc = m_val && m_rdy && clr_n && !rst;
            @(posedge clk);
            #1;
            if (acc && in_q.size() > 0) void'(in_q.pop_front());
            if (in_q.size() > 0 && !(gap_en && $urandom_range(3) == 0)) begin
                m_val = 1'b1;
                m_eof = in_q[0].eof;
                m_dat = in_q[0].dat;
            end else begin
                m_val = 1'b0;
                m_eof = 1'b0;
                m_dat = '0;
            end
        end
    end

    // Beat capture and input-stall counter, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && clr_n && s_val && s_rdy) cap_q.push_back({s_keep, s_eof, s_frag, s_dat});
        if (!rst && m_val && !m_rdy) stall_cnt++;
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1; clr_n = 1'b1; s_rdy = 1'b0;
        in_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cap_q.delete();
        stall_cnt = 0;
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (cap_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_in_empty(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (in_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clr_n = 1'b1; s_rdy = 1'b0; bpp = 2'd0;
        repeat (3) @(negedge clk);
        n_checks++; if (s_val !== 1'b0) begin n_fail++; $display("FAIL reset_s_val: got %b want 0", s_val); end
        n_checks++; if (s_eof !== 1'b0) begin n_fail++; $display("FAIL reset_s_eof: got %b want 0", s_eof); end
        n_checks++; if (s_keep !== '0) begin n_fail++; $display("FAIL reset_s_keep: got %b want 0", s_keep); end
        n_checks++; if (s_frag !== 1'b0) begin n_fail++; $display("FAIL reset_s_frag: got %b want 0", s_frag); end
        n_checks++; if (s_dat !== '0) begin n_fail++; $display("FAIL reset_s_dat: got %h want 0", s_dat); end
        n_checks++; if (m_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_m_rdy: got %b want 1", m_rdy); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_bytes_p1();
        beat_t exp_q[$];
        bit ok;
        apply_reset();
        bpp = 2'd0; s_rdy = 1'b1;
        in_q.push_back({1'b0, 32'h03020100});
        in_q.push_back({1'b1, 32'h07060504});
        exp_q.push_back({2'b11, 1'b0, 1'b0, 64'h00000001_00000000});
        exp_q.push_back({2'b11, 1'b0, 1'b0, 64'h00000003_00000002});
        exp_q.push_back({2'b11, 1'b0, 1'b0, 64'h00000005_00000004});
        exp_q.push_back({2'b11, 1'b1, 1'b0, 64'h00000007_00000006});
        wait_beats(4, 100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL p1_timeout: got %0d beats want 4", cap_q.size()); end
        repeat (4) @(negedge clk);
        n_checks++; if (cap_q.size() != 4) begin n_fail++; $display("FAIL p1_count: got %0d want 4", cap_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL p1_beat%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_straddle_p3();
        bit ok;
        beat_t e0, e1;
        apply_reset();
        bpp = 2'd2; s_rdy = 1'b1;
        in_q.push_back({1'b0, 32'h03020100});
        in_q.push_back({1'b0, 32'h07060504});
        in_q.push_back({1'b1, 32'h0B0A0908});
        e0 = {2'b11, 1'b0, 1'b0, 64'h00050403_00020100};
        e1 = {2'b11, 1'b1, 1'b0, 64'h000B0A09_00080706};
        wait_beats(2, 100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL p3_timeout: got %0d beats want 2", cap_q.size()); end
        n_checks++; if (cap_q[0] !== e0) begin n_fail++; $display("FAIL p3_beat0: got %h want %h", cap_q[0], e0); end
        n_checks++; if (cap_q[1] !== e1) begin n_fail++; $display("FAIL p3_beat1: got %h want %h", cap_q[1], e1); end
        n_checks++; if (stall_cnt != 0) begin n_fail++; $display("FAIL p3_no_stall: got %0d stalls want 0", stall_cnt); end
    endtask

    task automatic test_frag();
        bit ok;
        beat_t e0;
        apply_reset();
        bpp = 2'd2; s_rdy = 1'b1;
        in_q.push_back({1'b0, 32'h03020100});
        in_q.push_back({1'b1, 32'h07060504});
        e0 = {2'b11, 1'b1, 1'b1, 64'h00050403_00020100};
        wait_beats(1, 100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL frag_timeout: got %0d beats want 1", cap_q.size()); end
        n_checks++; if (cap_q[0] !== e0) begin n_fail++; $display("FAIL frag_beat: got %h want %h", cap_q[0], e0); end
        repeat (2) @(negedge clk);
        n_checks++; if (s_val !== 1'b0) begin n_fail++; $display("FAIL frag_empty_val: got %b want 0", s_val); end
        n_checks++; if (m_rdy !== 1'b1) begin n_fail++; $display("FAIL frag_empty_rdy: got %b want 1", m_rdy); end
        n_checks++; if (cap_q.size() != 1) begin n_fail++; $display("FAIL frag_count: got %0d want 1", cap_q.size()); end
    endtask

    task automatic test_single_lane();
        bit ok;
        beat_t e0;
        apply_reset();
        bpp = 2'd3; s_rdy = 1'b1;
        in_q.push_back({1'b1, 32'h03020100});
        e0 = {2'b01, 1'b1, 1'b0, 64'h00000000_03020100};
        wait_beats(1, 100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL p4_timeout: got %0d beats want 1", cap_q.size()); end
        n_checks++; if (cap_q[0] !== e0) begin n_fail++; $display("FAIL p4_beat: got %h want %h", cap_q[0], e0); end
    endtask

    task automatic test_back_to_back();
        bit ok, have;
        logic [SDW-1:0] snap;
        logic [15:0] l0, l1;
        beat_t e;
        apply_reset();
        bpp = 2'd1; s_rdy = 1'b0; have = 1'b0; snap = '0;
        for (int w = 0; w < 8; w++)
            in_q.push_back({w == 7, 8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
        repeat (10) begin
            @(negedge clk);
            if (s_val) begin
                if (!have) begin
                    snap = s_dat; have = 1'b1;
                end else begin
                    n_checks++;
                    if (s_dat !== snap) begin n_fail++; $display("FAIL stall_hold: got %h want %h", s_dat, snap); end
                end
            end
        end
        n_checks++; if (m_rdy !== 1'b0) begin n_fail++; $display("FAIL stall_m_rdy: got %b want 0", m_rdy); end
        n_checks++; if (s_val !== 1'b1) begin n_fail++; $display("FAIL stall_s_val: got %b want 1", s_val); end
        @(posedge clk); #1;
        s_rdy = 1'b1;
        wait_beats(8, 200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_timeout: got %0d beats want 8", cap_q.size()); end
        for (int b = 0; b < 8; b++) begin
            l0 = {8'(4*b+1), 8'(4*b)};
            l1 = {8'(4*b+3), 8'(4*b+2)};
            e  = {2'b11, b == 7, 1'b0, 16'h0, l1, 16'h0, l0};
            n_checks++;
            if (cap_q[b] !== e) begin n_fail++; $display("FAIL stall_beat%0d: got %h want %h", b, cap_q[b], e); end
        end
    endtask

    task automatic test_abort(input bit use_rst);
        bit ok;
        beat_t e0, e1;
        apply_reset();
        bpp = 2'd0; s_rdy = 1'b0;
        in_q.push_back({1'b0, 32'h03020100});
        in_q.push_back({1'b1, 32'h07060504});
        wait_in_empty(50, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_fill_timeout: got %0d words left want 0", in_q.size()); end
        @(posedge clk); #1; s_rdy = 1'b1;
        @(posedge clk); #1; s_rdy = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({s_val, s_keep, s_eof, s_dat} !== {1'b1, 2'b11, 1'b0, 64'h00000003_00000002}) begin
            n_fail++; $display("FAIL abort_pre_state: got %b %b %b %h want 1 11 0 0000000300000002", s_val, s_keep, s_eof, s_dat);
        end
        @(posedge clk); #1;
        if (use_rst) rst = 1'b1; else clr_n = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; clr_n = 1'b1;
        @(negedge clk);
        n_checks++; if (s_val !== 1'b0) begin n_fail++; $display("FAIL abort_s_val(rst=%0d): got %b want 0", use_rst, s_val); end
        n_checks++; if (m_rdy !== 1'b1) begin n_fail++; $display("FAIL abort_m_rdy(rst=%0d): got %b want 1", use_rst, m_rdy); end
        cap_q.delete();
        s_rdy = 1'b1;
        in_q.push_back({1'b1, 32'h13121110});
        e0 = {2'b11, 1'b0, 1'b0, 64'h00000011_00000010};
        e1 = {2'b11, 1'b1, 1'b0, 64'h00000013_00000012};
        wait_beats(2, 100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_next_timeout: got %0d beats want 2", cap_q.size()); end
        n_checks++; if (cap_q[0] !== e0) begin n_fail++; $display("FAIL abort_next_beat0: got %h want %h", cap_q[0], e0); end
        n_checks++; if (cap_q[1] !== e1) begin n_fail++; $display("FAIL abort_next_beat1: got %h want %h", cap_q[1], e1); end
    endtask

    task automatic test_random();
        byte unsigned mq[$];
        bit mpend, ev, ee, ef, er, spawn;
        int frames, cyc, p, n, k, tail, rem, nw;
        logic [LANES-1:0] ek;
        logic [SDW-1:0] ed;
        apply_reset();
        gap_en = 1'b1; mpend = 1'b0; frames = 0; cyc = 0;
        @(negedge clk);
        while (frames < 40 && cyc < 20000) begin
            // Expected outputs from the buffered byte list
            p    = int'(bpp) + 1;
            n    = mq.size();
            k    = n / p;
            if (k > int'(LANES)) k = LANES;
            tail = n - k * p;
            ev   = mpend || (n >= int'(LANES) * p);
            ee   = mpend && (tail < p);
            ef   = ee && (tail != 0);
            ek   = ev ? LANES'((1 << k) - 1) : '0;
            er   = !mpend && (n + int'(WB) <= int'(CAP));
            ed   = '0;
            if (ev)
                for (int i = 0; i < k; i++)
                    for (int b = 0; b < p; b++)
                        ed[i*PW + b*BW +: BW] = mq[i*p + b];
            n_checks++; if (m_rdy !== er) begin n_fail++; $display("FAIL rnd_m_rdy cyc%0d: got %b want %b", cyc, m_rdy, er); end
            n_checks++; if (s_val !== ev) begin n_fail++; $display("FAIL rnd_s_val cyc%0d: got %b want %b", cyc, s_val, ev); end
            if (ev) begin
                n_checks++; if (s_keep !== ek) begin n_fail++; $display("FAIL rnd_keep cyc%0d: got %b want %b", cyc, s_keep, ek); end
                n_checks++; if (s_eof !== ee) begin n_fail++; $display("FAIL rnd_eof cyc%0d: got %b want %b", cyc, s_eof, ee); end
                n_checks++; if (s_frag !== ef) begin n_fail++; $display("FAIL rnd_frag cyc%0d: got %b want %b", cyc, s_frag, ef); end
                n_checks++; if (s_dat !== ed) begin n_fail++; $display("FAIL rnd_dat cyc%0d: got %h want %h", cyc, s_dat, ed); end
            end
            // Advance the model by this cycle's handshakes
            if (ev && s_rdy) begin
                rem = ee ? n : k * p;
                repeat (rem) void'(mq.pop_front());
                if (ee) begin mpend = 1'b0; frames++; end
            end
            if (m_val && er) begin
                for (int b = 0; b < int'(WB); b++) mq.push_back(m_dat[b*BW +: BW]);
                if (m_eof) mpend = 1'b1;
            end
            spawn = (in_q.size() == 0) && !m_val && (mq.size() == 0) && !mpend;
            @(posedge clk); #1;
            s_rdy = ($urandom_range(3) != 0);
            if (spawn) begin
                bpp = 2'($urandom_range(3));
                nw  = $urandom_range(1, 6);
                for (int w = 0; w < nw; w++) in_q.push_back({w == nw - 1, 32'($urandom)});
            end
            @(negedge clk);
            cyc++;
        end
        n_checks++; if (frames < 40) begin n_fail++; $display("FAIL rnd_timeout: got %0d frames want 40", frames); end
        gap_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr_n = 1'b1; s_rdy = 1'b0; bpp = 2'd0;
        test_reset();
        test_bytes_p1();
        test_straddle_p3();
        test_frag();
        test_single_lane();
        test_back_to_back();
        test_abort(1'b0);
        test_abort(1'b1);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xlib_stream_w2p_mlane.md
# xlib_stream_w2p_mlane

Multi-lane word-to-primitive unpacker. It slices a stream of DW-bit words into primitives of runtime-selected byte size and emits up to LANES primitives per output beat. Primitives may straddle word boundaries at any alignment without input stalls. Frame ends are handled explicitly: a partial last beat, lane-valid mask and fragment flag are produced. It sits between a DMA read master and downstream pixel/sample pipelines that consume several primitives per clock.

## Interface
- BW, 8, byte width in bits
- DW, 32, input word width; DW/BW must be a power of 2
- PW, 32, maximum primitive width; multiple of BW, <=DW
- LANES, 2, primitives per output beat, 1..8
- WB, DW/BW, bytes per input word (derived)
- PB, PW/BW, max bytes per primitive (derived)
- CAP, WB+LANES*PB, byte buffer capacity (derived)
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- clr_n  in  1  synchronous clear, active low
- bpp  in  max(1,$clog2(PB))  bytes per primitive minus 1 (P = bpp+1, P<=PB)
- m_rdy  out  1  input ready
- m_val  in  1  input valid
- m_eof  in  1  last word of frame
- m_dat  in  DW  input word, byte 0 in bits [BW-1:0]
- s_rdy  in  1  output ready
- s_val  out  1  output valid
- s_eof  out  1  last beat of frame
- s_keep  out  LANES  lane-valid mask, contiguous from lane 0
- s_frag  out  1  qualified by s_eof: trailing bytes (<P) were discarded
- s_dat  out  LANES*PW  lane i at [i*PW +: PW]; primitive bytes low-aligned, unused upper bytes and invalid lanes 0

## Operation
- Byte buffer of CAP entries plus count `cnt` (0..CAP). Output reads from byte 0, and input appends at byte `cnt`.
- States: ACCUM (eof_pend=0) and DRAIN (eof_pend=1).
- m_rdy = !eof_pend && (cnt+WB <= CAP). It depends only on registers, with no combinational path from s_rdy.
- Accept (m_val&&m_rdy): append WB bytes. If m_eof, set eof_pend (enter DRAIN).
- Let k = min(LANES, floor(cnt/P)), computed by comparing cnt against j*P for j=1..LANES.
- ACCUM: s_val = (cnt >= LANES*P), s_keep all ones, s_eof=0.
- DRAIN: s_val=1.
  - s_keep has its low k bits set.
  - s_eof = (cnt - k*P < P).
  - s_frag = s_eof && (cnt - k*P != 0).
  - k=0 yields an empty eof beat: keep=0, s_frag=(cnt!=0).
- Emit (s_val&&s_rdy): remove k*P bytes, or all cnt bytes when s_eof. If s_eof, clear eof_pend and return to ACCUM.
- Accept and emit in the same cycle: cnt_next = cnt + WB - removed. The buffer shifts and appends in one step.
- bpp may change only when cnt==0 and in ACCUM. Otherwise, behaviour is undefined.
- clr_n=0: cnt=0, eof_pend=0 next edge. Clear overrides same-cycle accept and emit.

## Timing
- Reset (rst=1, asynchronous): cnt=0, eof_pend=0, buffer 0. Outputs: s_val=0, s_eof=0, s_keep=0, s_frag=0, s_dat=0, m_rdy=1.
- Latency: word accepted at edge N is visible on s_dat from cycle N+1. First s_val is earliest at N+1.
- Throughput: one word per cycle sustained whenever the output keeps up, since cnt+WB<=CAP holds at steady state.
- s_val/s_dat/s_keep/s_eof hold stable while s_val && !s_rdy. They change only after an emit, accept or clear edge.
- Words of the next frame are not accepted until the eof beat of the current frame is emitted.
- Reset or clr_n mid-frame: buffered bytes are discarded. No eof beat is produced for the aborted frame.

## Test plan
- DW=32, LANES=2, bpp=0. Words 0x03020100, 0x07060504(eof). Required beats, lanes {0,1}: {00,01}, {02,03}, {04,05}, {06,07}, keep=11. s_eof on beat 4 only, s_frag=0.
- bpp=2 (P=3). Words 0x03020100, 0x07060504, 0x0B0A0908(eof). Required: {020100,050403}, then {080706,0B0A09} with eof. keep=11, frag=0. No input stall.
- bpp=2. Words 0x03020100, 0x07060504(eof). Required: one beat {020100,050403}, keep=11, s_eof=1, s_frag=1 (bytes 06,07 dropped). cnt=0 after.
- bpp=3. Single word 0x03020100(eof). Required: one beat, keep=01, lane0=0x03020100, lane1=0, s_eof=1, frag=0.
- bpp=1, continuous input, s_rdy low 10 cycles. Required: m_rdy falls once cnt+4>12, with no byte lost or reordered. Outputs hold stable while stalled, and resume in order when s_rdy=1.
- clr_n pulse (and separately rst) mid-frame with cnt=6, eof pending. Required next cycle: s_val=0, m_rdy=1. The next frame unpacks from its byte 0.
